// File: rtl/sample_buffer.sv
// rtl/sample_buffer.sv - circular capture buffer with trigger, post-trigger count and newest-first UART readout
module sample_buffer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int DEPTH_LOG2   = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    valid_in,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    input  logic                    run,
    input  logic [15:0]             delay_count,
    input  logic [15:0]             read_count,
    input  logic                    tx_busy,
    output logic                    tx_en,
    output logic [7:0]              tx_data,
    output logic                    capturing,
    output logic                    busy,
    output logic                    capture_done
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef enum logic [3:0] {
        IDLE, ARMED, POST, RD_ADDR, RD_LOAD, SEND, WAIT_HI, WAIT_LO, DONE
    } state_t;

    state_t                  state, state_nx;
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
    logic [15:0]             post_cnt;
    logic [CW-1:0]           send_cnt;
    logic [CW-1:0]           read_clamped;
    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
    logic [SAMPLE_WIDTH-1:0] ram_q;
    logic                    wr_en;
    logic                    abort;

    assign abort        = arm && (state != IDLE);
    assign read_clamped = (32'(read_count) > DEPTH) ? CW'(DEPTH) : CW'(read_count);

    always_comb begin
        state_nx = state;
        tx_en    = 1'b0;
        wr_en    = 1'b0;
        case (state)
            IDLE:    if (arm) state_nx = ARMED;
            ARMED: begin
                wr_en = valid_in;
                if (run) state_nx = POST;
            end
            POST: begin
                if (post_cnt == '0) state_nx = RD_ADDR;
                else                wr_en = valid_in;
            end
            RD_ADDR: state_nx = (send_cnt == '0) ? DONE : RD_LOAD;
            RD_LOAD: state_nx = SEND;
            SEND: begin
                if (!tx_busy) begin
                    tx_en    = 1'b1;
                    state_nx = WAIT_HI;
                end
            end
            WAIT_HI: if (tx_busy) state_nx = WAIT_LO;
            WAIT_LO: if (!tx_busy) state_nx = (send_cnt > CW'(1)) ? RD_ADDR : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A restart overrides whatever the current state wanted to do this cycle
        if (abort) begin
            state_nx = ARMED;
            tx_en    = 1'b0;
            wr_en    = 1'b0;
        end
    end

    assign capturing    = (state == ARMED) || (state == POST);
    assign busy         = (state != IDLE);
    assign capture_done = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            post_cnt <= '0;
            send_cnt <= '0;
            tx_data  <= '0;
        end else begin
            state <= state_nx;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (abort) begin
                post_cnt <= '0;
                send_cnt <= '0;
                rd_ptr   <= '0;
            end else begin
                case (state)
                    ARMED: begin
                        if (run) begin
                            post_cnt <= delay_count;
                            send_cnt <= read_clamped;
                        end
                    end
                    POST: begin
                        // Leaving POST: point at the most recently written sample
                        if (post_cnt == '0)   rd_ptr   <= wr_ptr - 1'b1;
                        else if (valid_in)    post_cnt <= post_cnt - 16'd1;
                    end
                    RD_LOAD: tx_data <= 8'(ram_q);
                    WAIT_LO: begin
                        if (!tx_busy) begin
                            send_cnt <= send_cnt - 1'b1;
                            rd_ptr   <= rd_ptr - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= data_in;
        ram_q <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_sample_buffer.sv
// tb/tb_sample_buffer.sv - directed self-checking bench for sample_buffer
module tb_sample_buffer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic        valid_in = 1'b0;
    logic [7:0]  data_in = '0;
    logic        run = 1'b0;
    logic [15:0] delay_count = '0;
    logic [15:0] read_count = '0;
    logic        tx_busy = 1'b0;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        capturing;
    logic        busy;
    logic        capture_done;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int p0;

    sample_buffer #(.SAMPLE_WIDTH(8), .DEPTH_LOG2(4)) dut (
        .clock(clock), .reset(reset), .arm(arm), .valid_in(valid_in),
        .data_in(data_in), .run(run), .delay_count(delay_count),
        .read_count(read_count), .tx_busy(tx_busy), .tx_en(tx_en),
        .tx_data(tx_data), .capturing(capturing), .busy(busy),
        .capture_done(capture_done)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (tx_en) pulses++;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic feed(input logic [7:0] v, input logic trig);
        valid_in = 1'b1;
        data_in  = v;
        run      = trig;
        step();
        valid_in = 1'b0;
        run      = 1'b0;
    endtask

    // UART model: busy rises the cycle after tx_en and holds for 10 cycles
    task automatic serve_byte(input string tag, input logic [7:0] exp, input logic last);
        int waited = 0;
        while (!tx_en && waited < 60) begin
            step();
            waited++;
        end
        chk({tag, "_tx_en"}, tx_en, 1);
        chk({tag, "_tx_data"}, tx_data, exp);
        step();
        tx_busy = 1'b1;
        repeat (10) step();
        chk({tag, "_tx_data_hold"}, tx_data, exp);
        tx_busy = 1'b0;
        step();
        chk({tag, "_capture_done"}, capture_done, last);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_tx_en", tx_en, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_capturing", capturing, 0);
        chk("rst_capture_done", capture_done, 0);
        reset = 1'b0;
        step();

        // Basic capture: trigger on 0x0A, 3 post samples, read 5
        delay_count = 16'd3;
        read_count  = 16'd5;
        arm_pulse();
        chk("t2_capturing", capturing, 1);
        for (int v = 1; v <= 16; v++) feed(8'(v), v == 10);
        p0 = pulses;
        serve_byte("t2_b0", 8'h0D, 1'b0);
        serve_byte("t2_b1", 8'h0C, 1'b0);
        serve_byte("t2_b2", 8'h0B, 1'b0);
        serve_byte("t2_b3", 8'h0A, 1'b0);
        serve_byte("t2_b4", 8'h09, 1'b1);
        step();
        chk("t2_pulses", pulses - p0, 5);
        chk("t2_idle", busy, 0);

        // Zero delay: trigger sample is newest
        delay_count = 16'd0;
        read_count  = 16'd2;
        arm_pulse();
        for (int v = 1; v <= 5; v++) feed(8'(v), v == 5);
        p0 = pulses;
        serve_byte("t3a_b0", 8'h05, 1'b0);
        serve_byte("t3a_b1", 8'h04, 1'b1);
        step();
        chk("t3a_pulses", pulses - p0, 2);

        // Zero read count: done two cycles after leaving POST
        read_count = 16'd0;
        arm_pulse();
        p0 = pulses;
        for (int v = 8'h21; v <= 8'h23; v++) feed(8'(v), v == 8'h23);
        chk("t3b_post", capturing, 1);
        step();
        chk("t3b_rd_addr", capture_done, 0);
        step();
        chk("t3b_done", capture_done, 1);
        step();
        chk("t3b_idle", busy, 0);
        chk("t3b_pulses", pulses - p0, 0);

        // Wrap-around on a 16-entry buffer, exact and clamped read counts
        for (int pass = 0; pass < 2; pass++) begin
            read_count = (pass == 0) ? 16'd16 : 16'd40;
            arm_pulse();
            for (int v = 0; v < 20; v++) feed(8'(v), v == 19);
            p0 = pulses;
            for (int i = 0; i < 16; i++)
                serve_byte(pass == 0 ? "t4_exact" : "t4_clamp", 8'(8'h13 - i), i == 15);
            step();
            chk(pass == 0 ? "t4_exact_pulses" : "t4_clamp_pulses", pulses - p0, 16);
        end

        // Sparse valid: post count advances only on valid samples
        delay_count = 16'd2;
        read_count  = 16'd4;
        arm_pulse();
        for (int v = 8'h31; v <= 8'h36; v++) begin
            feed(8'(v), v == 8'h34);
            data_in = 8'hEE;
            if (v == 8'h35) chk("t5_gap1", capturing, 1);
            step();
            if (v == 8'h35) chk("t5_gap2", capturing, 1);
            step();
        end
        p0 = pulses;
        serve_byte("t5_b0", 8'h36, 1'b0);
        serve_byte("t5_b1", 8'h35, 1'b0);
        serve_byte("t5_b2", 8'h34, 1'b0);
        serve_byte("t5_b3", 8'h33, 1'b1);
        step();
        chk("t5_pulses", pulses - p0, 4);

        // Abort during WAIT_HI of the second byte, then recapture
        delay_count = 16'd0;
        read_count  = 16'd4;
        arm_pulse();
        for (int v = 8'h41; v <= 8'h44; v++) feed(8'(v), v == 8'h44);
        p0 = pulses;
        serve_byte("t6_b0", 8'h44, 1'b0);
        for (int w = 0; w < 10 && !tx_en; w++) step();
        chk("t6_b1_tx_data", tx_data, 8'h43);
        step();
        arm = 1'b1;
        chk("t6_wait_hi_tx_en", tx_en, 0);
        step();
        arm = 1'b0;
        tx_busy = 1'b1;
        chk("t6_capturing", capturing, 1);
        repeat (9) step();
        tx_busy = 1'b0;
        step();
        chk("t6_abort_pulses", pulses - p0, 2);
        chk("t6_still_armed", capturing, 1);
        delay_count = 16'd1;
        read_count  = 16'd2;
        for (int v = 8'h51; v <= 8'h53; v++) feed(8'(v), v == 8'h52);
        serve_byte("t6_new_b0", 8'h53, 1'b0);
        serve_byte("t6_new_b1", 8'h52, 1'b1);
        step();
        chk("t6_total_pulses", pulses - p0, 4);

        // Reset in the middle of WAIT_LO
        delay_count = 16'd0;
        read_count  = 16'd2;
        arm_pulse();
        for (int v = 8'h61; v <= 8'h62; v++) feed(8'(v), v == 8'h62);
        for (int w = 0; w < 10 && !tx_en; w++) step();
        step();
        tx_busy = 1'b1;
        step();
        chk("t1_pre_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("t1_tx_en", tx_en, 0);
        chk("t1_busy", busy, 0);
        chk("t1_capturing", capturing, 0);
        chk("t1_tx_data", tx_data, 0);
        step();
        reset   = 1'b0;
        tx_busy = 1'b0;
        run     = 1'b1;
        repeat (3) step();
        chk("t1_run_ignored_busy", busy, 0);
        chk("t1_run_ignored_cap", capturing, 0);
        run = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sample_buffer.md
Name: sample_buffer

Overview:
- Circular capture memory between the sampler/trigger stages and the UART transmitter.
- Continuously stores valid samples once armed. On the trigger `run` it captures a programmed number of post-trigger samples.
- It then reads the buffer back newest-first, one byte per UART transmission, using the `tx_busy` handshake.
- Replaces the direct sampler-to-UART data path in the transmit mux.

Parameters:
- SAMPLE_WIDTH, 8, sample width in bits; must be 1..8 (transmitted zero-extended to 8 bits).
- DEPTH_LOG2, 12, log2 of buffer depth; depth = 4096 samples.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- arm  input  1  one-cycle pulse; start/restart capture.
- valid_in  input  1  `data_in` is a new sample this cycle.
- data_in  input  SAMPLE_WIDTH  sample from sampler.
- run  input  1  trigger fired (level or pulse; first cycle seen while ARMED is used).
- delay_count  input  16  post-trigger samples to store; sampled on trigger.
- read_count  input  16  samples to transmit; sampled on trigger; clamped to 2^DEPTH_LOG2.
- tx_busy  input  1  UART transmitter busy.
- tx_en  output  1  one-cycle pulse: transmit `tx_data`.
- tx_data  output  8  byte to transmit; stable from `tx_en` until `tx_busy` falls.
- capturing  output  1  high in ARMED and POST.
- busy  output  1  high in any state except IDLE.
- capture_done  output  1  one-cycle pulse when readout completes.

Behaviour:
- Reset (async, any state):
  - state=IDLE; wr_ptr=0, rd_ptr=0, post_cnt=0, send_cnt=0.
  - tx_en=0, tx_data=0, capturing=0, busy=0, capture_done=0.
  - RAM contents are not cleared.
- RAM: single-port-write/single-port-read, synchronous read, 1-cycle latency.
- Write rule:
  - In ARMED or POST with valid_in=1: mem[wr_ptr]<=data_in; wr_ptr<=wr_ptr+1.
  - wr_ptr wraps modulo depth with no overflow flag; the oldest data is overwritten.
- States and transitions:
  - IDLE: `arm` -> ARMED.
  - ARMED: write rule applies. On `run`=1:
    - the same-cycle valid sample is written;
    - post_cnt<=delay_count; send_cnt<=min(read_count, depth);
    - -> POST.
  - POST:
    - If post_cnt==0 -> RD_ADDR; no write in this cycle.
    - Else the write rule applies, and post_cnt decrements on each valid_in.
    - So delay_count=0 stores no post-trigger samples beyond the trigger cycle.
  - RD_ADDR:
    - On entry rd_ptr = wr_ptr-1 (most recent sample, modulo depth).
    - If send_cnt==0 -> DONE. Else present rd_ptr to RAM -> RD_LOAD.
  - RD_LOAD: tx_data<={zero-ext RAM out} -> SEND.
  - SEND: when tx_busy==0, tx_en=1 for exactly one cycle -> WAIT_HI.
  - WAIT_HI: wait for tx_busy==1 -> WAIT_LO.
  - WAIT_LO: wait for tx_busy==0:
    - send_cnt--, rd_ptr-- (wraps from 0 to depth-1);
    - -> RD_ADDR if send_cnt>1 before the decrement, else DONE.
  - DONE: capture_done=1 for one cycle -> IDLE.
- Ordering: bytes are sent newest-first. The last byte sent is the sample read_count-1 positions before the newest.
- Fewer than read_count samples written since arm: stale RAM contents are transmitted; no error is flagged.
- `arm` in any non-IDLE state: abort.
  - tx_en=0 that cycle; counters cleared; wr_ptr retained; -> ARMED.
  - An in-flight UART byte completes externally.
- `arm` and `run` in the same cycle from IDLE: `arm` wins; `run` is ignored that cycle.
- `run` outside ARMED: ignored.
- valid_in outside ARMED/POST: ignored.
- Reset mid-readout: tx_en drops immediately (async), state goes to IDLE.
- Throughput: one byte per UART frame. Overhead is 3 cycles per byte (RD_ADDR, RD_LOAD, SEND) plus the busy handshake.

Test Plan:
1. Reset: assert reset mid-WAIT_LO -> tx_en=0, busy=0, capturing=0 in the same cycle. After release, state IDLE; `run` alone does nothing.
2. Basic capture:
   - Setup: arm; feed samples 0x01..0x10 every cycle; run at sample 0x0A; delay_count=3, read_count=5; UART model raises busy 1 cycle after tx_en and holds it 10 cycles.
   - Required: tx_data sequence 0x0D,0x0C,0x0B,0x0A,0x09; exactly 5 tx_en pulses; capture_done after the 5th busy fall.
3. Zero counts:
   - delay_count=0, read_count=2, run at 0x05 -> sends 0x05,0x04.
   - read_count=0 -> no tx_en; capture_done 2 cycles after POST exit.
4. Wrap-around: DEPTH_LOG2=4; write 20 samples 0x00..0x13 with run on the last; delay_count=0, read_count=16 -> sends 0x13 down to 0x04; read_count=40 clamps to 16 bytes.
5. Sparse valid: valid_in every 3rd cycle -> stored count equals number of valid pulses; post_cnt decrements only on valid.
6. Abort: arm during WAIT_HI of the 2nd byte -> no further tx_en, capturing=1 next cycle, a new capture completes normally.
